// File: rtl/nios_128k_extended_button_poller.sv
// rtl/nios_128k_extended_button_poller.sv - Avalon-MM PIO poller with debounce, edge pulses and sticky press irq
module nios_128k_extended_button_poller #(
  parameter int WIDTH        = 2,
  parameter int POLL_DIV     = 50000,
  parameter int STABLE_POLLS = 4,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  output logic [1:0]        m_address,
  output logic              m_read,
  input  logic [31:0]       m_readdata,
  output logic [WIDTH-1:0]  stable,
  output logic [WIDTH-1:0]  rise,
  output logic [WIDTH-1:0]  fall,
  output logic              irq,
  input  logic              irq_ack
);

  localparam int DW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
  localparam int CW = $clog2(STABLE_POLLS + 1);
  localparam int LW = (READ_LATENCY > 2) ? $clog2(READ_LATENCY - 1) : 1;
  localparam logic [DW-1:0] DIV_MAX = DW'(POLL_DIV - 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_POLLS);
  localparam logic [LW-1:0] LAT_MAX = LW'((READ_LATENCY > 1) ? READ_LATENCY - 2 : 0);
  localparam bit LAT0 = (READ_LATENCY == 0);
  localparam bit LAT1 = (READ_LATENCY == 1);

  typedef enum logic [1:0] {IDLE, READ, WAIT, CAPTURE} state_t;

  state_t            state_q;
  logic [DW-1:0]     div_cnt_q;
  logic [LW-1:0]     lat_cnt_q;
  logic              m_read_q;
  logic [WIDTH-1:0]  cand_q, cand_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  stable_q, stable_d;
  logic [WIDTH-1:0]  rise_q, rise_d;
  logic [WIDTH-1:0]  fall_q, fall_d;
  logic [WIDTH-1:0]  pending_q, pending_d;
  logic              irq_q;
  logic              tick;
  logic              capture;
  logic [WIDTH-1:0]  sample;
  logic              unused_readdata;

  assign tick    = enable && (div_cnt_q == DIV_MAX);
  assign capture = (state_q == CAPTURE) || (LAT0 && (state_q == READ));
  assign sample  = m_readdata[WIDTH-1:0];
  assign unused_readdata = ^m_readdata;

  always_comb begin
    cand_d   = cand_q;
    cnt_d    = cnt_q;
    stable_d = stable_q;
    rise_d   = '0;
    fall_d   = '0;
    if (capture) begin
      if (sample == cand_q) begin
        if (cnt_q != CNT_MAX) cnt_d = cnt_q + CW'(1);
      end else begin
        cand_d = sample;
        cnt_d  = CW'(1);
      end
      if ((cnt_d >= CNT_MAX) && (cand_d != stable_q)) begin
        stable_d = cand_d;
        rise_d   = cand_d & ~stable_q;
        fall_d   = ~cand_d & stable_q;
      end
    end
    // rise_q keeps the set alive through the pulse cycle so a coincident ack cannot drop it
    pending_d = (irq_ack ? '0 : pending_q) | rise_d | rise_q;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      div_cnt_q <= '0;
      lat_cnt_q <= '0;
      m_read_q  <= 1'b0;
      cand_q    <= '0;
      cnt_q     <= '0;
      stable_q  <= '0;
      rise_q    <= '0;
      fall_q    <= '0;
      pending_q <= '0;
      irq_q     <= 1'b0;
    end else begin
      if (!enable || (div_cnt_q == DIV_MAX)) div_cnt_q <= '0;
      else                                    div_cnt_q <= div_cnt_q + DW'(1);

      m_read_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (tick) begin
            state_q  <= READ;
            m_read_q <= 1'b1;
          end
        end
        READ: begin
          if (LAT0)      state_q <= IDLE;
          else if (LAT1) state_q <= CAPTURE;
          else begin
            state_q   <= WAIT;
            lat_cnt_q <= '0;
          end
        end
        WAIT: begin
          if (lat_cnt_q == LAT_MAX) state_q <= CAPTURE;
          else                      lat_cnt_q <= lat_cnt_q + LW'(1);
        end
        CAPTURE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase

      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      stable_q  <= stable_d;
      rise_q    <= rise_d;
      fall_q    <= fall_d;
      pending_q <= pending_d;
      irq_q     <= |pending_q;
    end
  end

  assign m_address = 2'b00;
  assign m_read    = m_read_q;
  assign stable    = stable_q;
  assign rise      = rise_q;
  assign fall      = fall_q;
  assign irq       = irq_q;

endmodule
